demodulation: RTL
=================

DEMODULATION -- requirements
Module: demodulation

Interface
REQ-001 Parameter CodeLen, default 256, sets the codeword length in samples.
REQ-002 Parameter CodeLen_bits, default 8, sets the sample address width; address ports are CodeLen_bits+1 bits wide.
REQ-003 Parameter LLR_W, default 6, sets the signed LLR output width.
REQ-004 Parameter LLR_SHIFT, default 8, sets the arithmetic right shift from fix5p10 to LLR.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 modulation_down  in  1  modulator has filled the sample RAM.
REQ-008 demodulation_receive  out  1  acknowledge of modulation_down.
REQ-009 demodulation_down_to_modulation  out  1  sample RAM has been fully read and is free.
REQ-010 demodulation_down_to_modulation_receive  in  1  modulator acknowledge of RAM release.
REQ-011 read_enable  out  1  RAM read strobe for both ports.
REQ-012 read_addr  out  CodeLen_bits+1  port-a address; port b reads read_addr+1.
REQ-013 rdata_a, rdata_b  in  15 each  signed fix5p10 samples, valid exactly 1 cycle after read_enable.
REQ-014 llr_we  out  1  LLR pair write strobe.
REQ-015 llr_addr  out  CodeLen_bits+1  LLR address of llr_a; llr_b belongs to llr_addr+1.
REQ-016 llr_a, llr_b  out  LLR_W each  signed saturated LLRs.
REQ-017 hard_sequence  out  CodeLen  hard decisions; bit k belongs to sample k.
REQ-018 demod_valid  out  1  LLRs and hard_sequence are complete for the decoder.
REQ-019 decoder_ack  in  1  decoder has consumed the frame.

Function
REQ-020 The state machine SHALL have the states IDLE, READ, DRAIN and DONE; any other encoding returns to IDLE.
REQ-021 IDLE: when modulation_down=1, the block SHALL set demodulation_receive=1, reset the read counter to 0, clear hard_sequence and move to READ on the next edge.
REQ-022 demodulation_receive SHALL stay at 1 until modulation_down is sampled 0, then clear on the following edge.
REQ-023 READ: each cycle while counter<CodeLen, the block SHALL assert read_enable with read_addr=counter and then add 2 to the counter.
REQ-024 READ: when counter>=CodeLen, the block SHALL deassert read_enable and go to DRAIN.
REQ-025 Each read SHALL produce, 1 cycle later, one llr_we pulse with llr_addr equal to the issued read_addr, using a registered valid/address pipeline.
REQ-026 LLR SHALL equal the sample arithmetically shifted right by LLR_SHIFT (rounding toward -inf), then saturated to ±(2^(LLR_W-1)-1); the saturation range is symmetric.
REQ-027 The hard bit SHALL be the sample's sign bit (negative gives 1, zero or positive gives 0), written into hard_sequence[addr] and hard_sequence[addr+1] in the same cycle as llr_we.
REQ-028 DRAIN SHALL last 1 cycle, complete the final llr_we, then go to DONE.
REQ-029 DONE entry: the block SHALL assert demod_valid and demodulation_down_to_modulation at the same time.
REQ-030 Each DONE output SHALL hold until its own acknowledge (decoder_ack or demodulation_down_to_modulation_receive) is sampled 1, then clear on the next edge.
REQ-031 The two DONE handshakes are independent; they may complete in either order or in the same cycle.
REQ-032 DONE SHALL return to IDLE on the edge where the last outstanding handshake clears.
REQ-033 hard_sequence SHALL hold its value after DONE until the next frame starts in IDLE.
REQ-034 A modulation_down that arrives outside IDLE SHALL be ignored; an acknowledge that arrives while its request is low SHALL be ignored.
REQ-035 Maximum frame latency from modulation_down to demod_valid SHALL be CodeLen/2+3 cycles.

Reset
REQ-036 While rst=1, regardless of clk, the block SHALL force: state=IDLE, counter=0, every 1-bit output=0, read_addr=0, llr_addr=0, llr_a=llr_b=0, hard_sequence=0.
REQ-037 A reset in any state, including mid-READ, SHALL abort the frame; the first rising edge after release starts in IDLE.

Verification
REQ-038 All samples 0x0400 (+1.0), CodeLen=256 -> 128 llr_we pulses, every LLR=+4, hard_sequence all 0, demod_valid at cycle 131 after modulation_down.
REQ-039 Sample pair 0x7C00 (-1.0) and 0x0000 -> llr_a=-4, llr_b=0, hard bits 1 and 0.
REQ-040 Samples 0x3FFF and 0x4000 -> llr_a=+31, llr_b=-31 (saturated).
REQ-041 decoder_ack 5 cycles before demodulation_down_to_modulation_receive -> demod_valid clears first, IDLE is entered only after the second acknowledge; also cover both acknowledges in the same cycle.
REQ-042 rst pulse at counter=100 in READ -> all outputs 0 immediately; a new modulation_down then gives a complete, correct frame.
REQ-043 modulation_down held high for 3 cycles -> demodulation_receive rises 1 cycle after modulation_down, falls 1 cycle after modulation_down falls, and no second frame starts.

Source files
------------

// File: rtl/demodulation_if.sv
// Port bundle for the demodulator: sample-RAM read bus, LLR write bus,
// hard decisions and the modulator/decoder handshakes.
`timescale 1ns/1ps
interface demodulation_if #(
  parameter int CodeLen      = 256,
  parameter int CodeLen_bits = 8,
  parameter int LLR_W        = 6
);
  logic                      modulation_down;
  logic                      demodulation_receive;
  logic                      demodulation_down_to_modulation;
  logic                      demodulation_down_to_modulation_receive;
  logic                      read_enable;
  logic [CodeLen_bits:0]     read_addr;
  logic signed [14:0]        rdata_a;
  logic signed [14:0]        rdata_b;
  logic                      llr_we;
  logic [CodeLen_bits:0]     llr_addr;
  logic signed [LLR_W-1:0]   llr_a;
  logic signed [LLR_W-1:0]   llr_b;
  logic [CodeLen-1:0]        hard_sequence;
  logic                      demod_valid;
  logic                      decoder_ack;

  // Demodulator side
  modport master (
    input  modulation_down, demodulation_down_to_modulation_receive,
           rdata_a, rdata_b, decoder_ack,
    output demodulation_receive, demodulation_down_to_modulation,
           read_enable, read_addr, llr_we, llr_addr, llr_a, llr_b,
           hard_sequence, demod_valid
  );

  // Modulator / RAM / decoder side
  modport slave (
    output modulation_down, demodulation_down_to_modulation_receive,
           rdata_a, rdata_b, decoder_ack,
    input  demodulation_receive, demodulation_down_to_modulation,
           read_enable, read_addr, llr_we, llr_addr, llr_a, llr_b,
           hard_sequence, demod_valid
  );
endinterface

// File: rtl/demodulation.sv
// Soft demodulator: reads fix5p10 sample pairs from the modulator RAM, emits
// saturated LLR pairs and hard decisions, then hands the frame to the decoder.
`timescale 1ns/1ps
module demodulation #(
  parameter int CodeLen      = 256,
  parameter int CodeLen_bits = 8,
  parameter int LLR_W        = 6,
  parameter int LLR_SHIFT    = 8
) (
  input  logic           clk,
  input  logic           rst,
  demodulation_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam int                AW       = CodeLen_bits + 1;
  localparam logic [AW-1:0]     CODE_LEN = AW'(CodeLen);
  localparam logic signed [14:0] SAT_HI  = 15'((1 << (LLR_W - 1)) - 1);
  localparam logic signed [14:0] SAT_LO  = -SAT_HI;

  state_t                  state;
  logic [AW-1:0]           counter;
  logic [CodeLen_bits-1:0] hard_idx_a;
  logic [CodeLen_bits-1:0] hard_idx_b;

  // Arithmetic shift floors toward -inf; the clamp is symmetric.
  function automatic logic signed [LLR_W-1:0] to_llr(input logic signed [14:0] s);
    logic signed [14:0] sh;
    sh = s >>> LLR_SHIFT;
    if (sh > SAT_HI) return SAT_HI[LLR_W-1:0];
    if (sh < SAT_LO) return SAT_LO[LLR_W-1:0];
    return sh[LLR_W-1:0];
  endfunction

  // Pairs always start on an even address, so the odd partner is just bit 0 set.
  assign hard_idx_a = bus.llr_addr[CodeLen_bits-1:0];
  assign hard_idx_b = {hard_idx_a[CodeLen_bits-1:1], 1'b1};

  // NOTE: every output gets a default first so no latch is inferred; the LLRs
  // stay combinational because rdata is only valid during the llr_we cycle.
  always_comb begin
    bus.llr_a = '0;
    bus.llr_b = '0;
    if (bus.llr_we) begin
      bus.llr_a = to_llr(bus.rdata_a);
      bus.llr_b = to_llr(bus.rdata_b);
    end
  end

  // NOTE: state uses non-blocking assignments only, so every branch below
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                               <= IDLE;
      counter                             <= '0;
      bus.demodulation_receive            <= 1'b0;
      bus.demodulation_down_to_modulation <= 1'b0;
      bus.read_enable                     <= 1'b0;
      bus.read_addr                       <= '0;
      bus.llr_we                          <= 1'b0;
      bus.llr_addr                        <= '0;
      bus.demod_valid                     <= 1'b0;
      // NOTE: hard_sequence is a plain flop vector, not a RAM, so it is reset
      // with everything else and the decoder never sees stale bits.
      bus.hard_sequence                   <= '0;
    end else begin
      bus.llr_we   <= bus.read_enable;
      bus.llr_addr <= bus.read_addr;
      if (bus.llr_we) begin
        bus.hard_sequence[hard_idx_a] <= bus.rdata_a[14];
        bus.hard_sequence[hard_idx_b] <= bus.rdata_b[14];
      end

      if (bus.demodulation_receive && !bus.modulation_down)
        bus.demodulation_receive <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.modulation_down) begin
            bus.demodulation_receive <= 1'b1;
            counter                  <= '0;
            bus.hard_sequence        <= '0;
            state                    <= READ;
          end
        end
        READ: begin
          if (counter < CODE_LEN) begin
            bus.read_enable <= 1'b1;
            bus.read_addr   <= counter;
            counter         <= counter + AW'(2);
          end else begin
            bus.read_enable <= 1'b0;
            state           <= DRAIN;
          end
        end
        DRAIN: begin
          bus.demod_valid                     <= 1'b1;
          bus.demodulation_down_to_modulation <= 1'b1;
          state                               <= DONE;
        end
        DONE: begin
          if (bus.demod_valid && bus.decoder_ack)
            bus.demod_valid <= 1'b0;
          if (bus.demodulation_down_to_modulation && bus.demodulation_down_to_modulation_receive)
            bus.demodulation_down_to_modulation <= 1'b0;
          // Leave once neither handshake remains outstanding after this edge.
          if ((!bus.demod_valid || bus.decoder_ack) &&
              (!bus.demodulation_down_to_modulation || bus.demodulation_down_to_modulation_receive))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
